reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard.sv | 96 +++++++++
 tb/tb_reg_scoreboard.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register counters of in-flight writes between issue and writeback.
// Drives the ID read-after-write stall, issue back-pressure on counter saturation, and a sticky underflow flag.
module reg_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            issue_valid,
  input  logic            issue_en_rd,
  input  logic [4:0]      issue_rd,
  output logic            issue_ready,
  input  logic            wb_valid,
  input  logic            wb_en_rd,
  input  logic [4:0]      wb_rd,
  input  logic            flush,
  input  logic [4:0]      q_rs1,
  input  logic [4:0]      q_rs2,
  input  logic            q_en_rs1,
  input  logic            q_en_rs2,
  output logic            q_stall,
  output logic [NREG-1:0] busy_vec,
  output logic            wb_underflow
);

  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] ONE  = 1;

  logic [CNT_W-1:0] count [NREG];

  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] wb_cnt;
  logic [CNT_W-1:0] rs1_cnt;
  logic [CNT_W-1:0] rs2_cnt;
  logic             issue_acc;
  logic             wb_req;
  logic             wb_acc;
  logic             underflow_set;

  // Index decode as a compare loop: register 0 and out-of-range indices read back as zero.
  always_comb begin
    issue_cnt = '0;
    wb_cnt    = '0;
    rs1_cnt   = '0;
    rs2_cnt   = '0;
    for (int i = 1; i < NREG; i++) begin
      if (issue_rd == i[4:0]) issue_cnt = count[i];
      if (wb_rd    == i[4:0]) wb_cnt    = count[i];
      if (q_rs1    == i[4:0]) rs1_cnt   = count[i];
      if (q_rs2    == i[4:0]) rs2_cnt   = count[i];
    end
  end

  always_comb begin
    issue_ready   = !(issue_en_rd && (issue_rd != 5'd0) && (issue_cnt == CMAX));
    issue_acc     = issue_valid && issue_en_rd && issue_ready && (issue_rd != 5'd0);
    wb_req        = wb_valid && wb_en_rd && (wb_rd != 5'd0);
    wb_acc        = wb_req && (wb_cnt != '0);
    underflow_set = wb_req && (wb_cnt == '0);
    q_stall       = (q_en_rs1 && (q_rs1 != 5'd0) && (rs1_cnt != '0)) ||
                    (q_en_rs2 && (q_rs2 != 5'd0) && (rs2_cnt != '0));
  end

  always_comb begin
    busy_vec = '0;
    for (int i = 0; i < NREG; i++) begin
      busy_vec[i] = (count[i] != '0);
    end
  end

  // Issue and retire to the same register cancel out; flush wins over both.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) count[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < NREG; i++) count[i] <= '0;
    end else begin
      count[0] <= '0;
      for (int i = 1; i < NREG; i++) begin
        if ((issue_acc && (issue_rd == i[4:0])) && !(wb_acc && (wb_rd == i[4:0])))
          count[i] <= count[i] + ONE;
        else if ((wb_acc && (wb_rd == i[4:0])) && !(issue_acc && (issue_rd == i[4:0])))
          count[i] <= count[i] - ONE;
      end
    end
  end

  // Sticky until reset; flush deliberately leaves it alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      wb_underflow <= 1'b0;
    else if (underflow_set)
      wb_underflow <= 1'b1;
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed, table-driven bench for reg_scoreboard with hand-computed expectations,
// plus a hand-written mid-operation reset sequence.
module tb_reg_scoreboard;

  logic        clk;
  logic        reset_n;
  logic        issue_valid;
  logic        issue_en_rd;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        wb_valid;
  logic        wb_en_rd;
  logic [4:0]  wb_rd;
  logic        flush;
  logic [4:0]  q_rs1;
  logic [4:0]  q_rs2;
  logic        q_en_rs1;
  logic        q_en_rs2;
  logic        q_stall;
  logic [31:0] busy_vec;
  logic        wb_underflow;

  int checks_done;
  int checks_failed;

  typedef struct {
    logic        iv;
    logic        ien;
    logic [4:0]  ird;
    logic        wv;
    logic        wen;
    logic [4:0]  wrd;
    logic        fl;
    logic [4:0]  rs1;
    logic        e1;
    logic [4:0]  rs2;
    logic        e2;
    logic        exp_ready;
    logic        exp_stall;
    logic [31:0] exp_busy;
    logic        exp_uf;
  } vec_t;

  vec_t vecs[$];

  reg_scoreboard #(.NREG(32), .CNT_W(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .issue_valid  (issue_valid),
    .issue_en_rd  (issue_en_rd),
    .issue_rd     (issue_rd),
    .issue_ready  (issue_ready),
    .wb_valid     (wb_valid),
    .wb_en_rd     (wb_en_rd),
    .wb_rd        (wb_rd),
    .flush        (flush),
    .q_rs1        (q_rs1),
    .q_rs2        (q_rs2),
    .q_en_rs1     (q_en_rs1),
    .q_en_rs2     (q_en_rs2),
    .q_stall      (q_stall),
    .busy_vec     (busy_vec),
    .wb_underflow (wb_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic iv, logic ien, logic [4:0] ird,
                              logic wv, logic wen, logic [4:0] wrd, logic fl,
                              logic [4:0] rs1, logic e1, logic [4:0] rs2, logic e2,
                              logic r, logic s, logic [31:0] b, logic uf);
    vec_t v;
    v.iv = iv;   v.ien = ien; v.ird = ird;
    v.wv = wv;   v.wen = wen; v.wrd = wrd;
    v.fl = fl;
    v.rs1 = rs1; v.e1 = e1;   v.rs2 = rs2; v.e2 = e2;
    v.exp_ready = r; v.exp_stall = s; v.exp_busy = b; v.exp_uf = uf;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    issue_valid = v.iv;  issue_en_rd = v.ien; issue_rd = v.ird;
    wb_valid    = v.wv;  wb_en_rd    = v.wen; wb_rd    = v.wrd;
    flush       = v.fl;
    q_rs1 = v.rs1; q_en_rs1 = v.e1; q_rs2 = v.rs2; q_en_rs2 = v.e2;
  endtask

  // Drive a new cycle's inputs shortly after the active edge.
  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    drive(v);
  endtask

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_done++;
    if (act !== exp) begin
      checks_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic r, input logic s,
                             input logic [31:0] b, input logic uf);
    compare({tag, " issue_ready"},  {31'd0, issue_ready},  {31'd0, r});
    compare({tag, " q_stall"},      {31'd0, q_stall},      {31'd0, s});
    compare({tag, " busy_vec"},     busy_vec,              b);
    compare({tag, " wb_underflow"}, {31'd0, wb_underflow}, {31'd0, uf});
  endtask

  initial begin
    vec_t idle;
    checks_done   = 0;
    checks_failed = 0;
    idle = mk(0,0,0, 0,0,0, 0, 0,0,0,0, 1,0,32'h0,0);

    //             iv ien ird  wv wen wrd fl  rs1 e1 rs2 e2  rdy stl busy          uf
    vecs.push_back(mk(0,0,0,   0,0,0,   0,  5,1, 0,0,  1,0, 32'h0,        0)); // 0 empty
    vecs.push_back(mk(1,1,5,   0,0,0,   0,  5,1, 0,0,  1,0, 32'h0,        0)); // 1 issue r5
    vecs.push_back(mk(0,0,0,   0,0,0,   0,  5,1, 0,0,  1,1, 32'h20,       0)); // 2 r5 pending
    vecs.push_back(mk(0,0,0,   1,1,5,   0,  5,1, 0,0,  1,1, 32'h20,       0)); // 3 retire r5, stall holds
    vecs.push_back(mk(0,0,0,   1,0,5,   0,  5,1, 0,0,  1,0, 32'h0,        0)); // 4 cleared; wb w/o en_rd
    vecs.push_back(mk(1,1,0,   1,1,0,   0,  0,1, 0,0,  1,0, 32'h0,        0)); // 5 rd=0 issue/retire
    vecs.push_back(mk(0,0,0,   0,0,0,   0,  0,1, 0,1,  1,0, 32'h0,        0)); // 6 r0 never tracked
    vecs.push_back(mk(1,1,7,   0,0,0,   0,  0,0, 0,0,  1,0, 32'h0,        0)); // 7 r7 -> 1
    vecs.push_back(mk(1,1,7,   0,0,0,   0,  0,0, 0,0,  1,0, 32'h80,       0)); // 8 r7 -> 2
    vecs.push_back(mk(1,1,7,   0,0,0,   0,  0,0, 0,0,  1,0, 32'h80,       0)); // 9 r7 -> 3
    vecs.push_back(mk(1,1,7,   0,0,0,   0,  0,0, 7,1,  0,1, 32'h80,       0)); // 10 saturated, blocked
    vecs.push_back(mk(1,1,8,   1,1,7,   0,  0,0, 0,0,  1,0, 32'h80,       0)); // 11 issue r8, retire r7
    vecs.push_back(mk(0,0,0,   1,1,7,   0,  8,1, 0,0,  1,1, 32'h180,      0)); // 12 r7 -> 1
    vecs.push_back(mk(0,1,7,   1,1,7,   0,  0,0, 0,0,  1,0, 32'h180,      0)); // 13 r7 -> 0
    vecs.push_back(mk(0,0,0,   1,1,8,   0,  7,1, 0,0,  1,0, 32'h100,      0)); // 14 r8 -> 0
    vecs.push_back(mk(1,1,3,   0,0,0,   0,  0,0, 0,0,  1,0, 32'h0,        0)); // 15 r3 -> 1
    vecs.push_back(mk(1,1,3,   1,1,3,   0,  0,0, 3,1,  1,1, 32'h8,        0)); // 16 same-reg cancel
    vecs.push_back(mk(0,0,0,   0,0,0,   0,  0,0, 3,1,  1,1, 32'h8,        0)); // 17 r3 still 1
    vecs.push_back(mk(1,1,4,   1,1,3,   0,  0,0, 3,1,  1,1, 32'h8,        0)); // 18 diff regs both apply
    vecs.push_back(mk(1,1,6,   0,0,0,   0,  3,1, 4,1,  1,1, 32'h10,       0)); // 19 r6 -> 1
    vecs.push_back(mk(1,1,4,   0,0,0,   0,  0,0, 0,0,  1,0, 32'h50,       0)); // 20 r4 -> 2
    vecs.push_back(mk(1,1,10,  1,1,6,   1,  4,1, 6,1,  1,1, 32'h50,       0)); // 21 flush wins
    vecs.push_back(mk(0,0,0,   0,0,0,   0,  4,1, 6,1,  1,0, 32'h0,        0)); // 22 all clear
    vecs.push_back(mk(0,0,0,   0,0,0,   0,  10,1, 4,1, 1,0, 32'h0,        0)); // 23 r10 dropped
    vecs.push_back(mk(0,0,0,   1,1,9,   0,  0,0, 0,0,  1,0, 32'h0,        0)); // 24 underflow r9
    vecs.push_back(mk(0,0,0,   0,0,0,   1,  0,0, 0,0,  1,0, 32'h0,        1)); // 25 sticky, flush
    vecs.push_back(mk(0,0,0,   0,0,0,   0,  9,1, 0,0,  1,0, 32'h0,        1)); // 26 survives flush

    reset_n = 1'b0;
    drive(idle);
    q_rs1 = 5'd5; q_en_rs1 = 1'b1; issue_en_rd = 1'b1; issue_rd = 5'd5;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset", 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    drive(idle);
    reset_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(vecs[k]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", k), vecs[k].exp_ready, vecs[k].exp_stall,
                  vecs[k].exp_busy, vecs[k].exp_uf);
    end

    // Mid-operation reset discards r12's counts and the sticky underflow.
    applyStimulus(mk(1,1,12, 0,0,0, 0, 12,1, 0,0, 1,0,32'h0,1));
    applyStimulus(mk(1,1,12, 0,0,0, 0, 12,1, 0,0, 1,1,32'h1000,1));
    @(posedge clk);
    #1;
    drive(mk(0,1,12, 0,0,0, 0, 12,1, 0,0, 1,0,32'h0,0));
    @(negedge clk);
    checkOutput("pre_reset", 1'b1, 1'b1, 32'h1000, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset", 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    drive(mk(1,1,12, 0,0,0, 0, 12,1, 0,0, 1,0,32'h0,0));
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    drive(mk(0,0,0, 1,1,12, 0, 12,1, 0,0, 1,0,32'h0,0));
    #1;
    checkOutput("post_reset_issue", 1'b1, 1'b1, 32'h1000, 1'b0);
    @(posedge clk);
    #1;
    drive(idle);
    q_rs1 = 5'd12; q_en_rs1 = 1'b1;
    #1;
    checkOutput("post_reset_retire", 1'b1, 1'b0, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks_done, checks_failed);
    $finish;
  end

endmodule
